// File: rtl/xsim_msg_pkg.sv
// xsim_msg_pkg: shared types and header field positions for the portal message deframer
package xsim_msg_pkg;

    typedef enum logic [1:0] {HDR, PAYLOAD, DROP} msg_state_t;

    typedef struct packed {
        logic [15:0] method;
        logic [31:0] data;
        logic        first;
        logic        last;
        logic        empty;
    } msg_entry_t;

    localparam int HDR_METHOD_MSB = 31;
    localparam int HDR_METHOD_LSB = 16;
    localparam int HDR_LEN_MSB    = 15;

endpackage

// File: rtl/xsim_msg_fifo.sv
// xsim_msg_fifo: power-of-2 synchronous FIFO of message entries with registered occupancy
module xsim_msg_fifo
    import xsim_msg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       push,
    input  msg_entry_t push_data,
    input  logic       pop,
    output msg_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    msg_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            do_push, do_pop;

    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // pointers wrap naturally; occupancy has one extra bit to represent full
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // storage needs no reset: head is masked to zero while empty
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/xsim_msg_deframer.sv
// xsim_msg_deframer: frames a 32-bit portal beat stream into tagged messages, dropping bad methods
module xsim_msg_deframer
    import xsim_msg_pkg::*;
#(
    parameter int NUM_METHODS = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        in_rdy,
    input  logic [31:0] in_beat,
    output logic        in_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] out_method,
    output logic        out_first,
    output logic        out_last,
    output logic        out_empty,
    output logic        err_bad_method,
    output logic [31:0] msg_count,
    output logic [15:0] drop_count
);

    msg_state_t  state, state_nxt;
    logic [15:0] method_r, method_nxt, remain_r, remain_nxt;
    logic        first_r, first_nxt;
    logic        push, full, fifo_empty, bad, inc_msg, inc_drop;
    msg_entry_t  push_entry, head;
    logic [15:0] hdr_m, hdr_len;
    logic        bad_m, short_len, last_w;

    assign hdr_m     = in_beat[HDR_METHOD_MSB:HDR_METHOD_LSB];
    assign hdr_len   = in_beat[HDR_LEN_MSB:0];
    assign bad_m     = 32'(hdr_m) >= 32'(NUM_METHODS);
    assign short_len = hdr_len <= 16'd1;
    assign last_w    = remain_r == 16'd1;

    // header parse, payload tagging and drop skipping on each accepted beat
    always_comb begin
        in_en      = in_rdy && (state == DROP || !full);
        state_nxt  = state;
        method_nxt = method_r;
        remain_nxt = remain_r;
        first_nxt  = first_r;
        push       = 1'b0;
        push_entry = '0;
        bad        = 1'b0;
        inc_msg    = 1'b0;
        inc_drop   = 1'b0;
        if (in_en) begin
            case (state)
                HDR: begin
                    if (bad_m) begin
                        bad = 1'b1;
                        if (short_len) inc_drop = 1'b1;
                        else begin
                            remain_nxt = hdr_len - 16'd1;
                            state_nxt  = DROP;
                        end
                    end else if (short_len) begin
                        push       = 1'b1;
                        push_entry = '{method: hdr_m, data: 32'd0, first: 1'b1, last: 1'b1, empty: 1'b1};
                        inc_msg    = 1'b1;
                    end else begin
                        method_nxt = hdr_m;
                        remain_nxt = hdr_len - 16'd1;
                        first_nxt  = 1'b1;
                        state_nxt  = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    push       = 1'b1;
                    push_entry = '{method: method_r, data: in_beat, first: first_r, last: last_w, empty: 1'b0};
                    first_nxt  = 1'b0;
                    remain_nxt = remain_r - 16'd1;
                    inc_msg    = last_w;
                    state_nxt  = last_w ? HDR : PAYLOAD;
                end
                DROP: begin
                    remain_nxt = remain_r - 16'd1;
                    inc_drop   = last_w;
                    state_nxt  = last_w ? HDR : DROP;
                end
                default: state_nxt = HDR;
            endcase
        end
    end

    // FSM context, error pulse and message/drop counters
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= HDR;
            method_r       <= '0;
            remain_r       <= '0;
            first_r        <= 1'b0;
            err_bad_method <= 1'b0;
            msg_count      <= '0;
            drop_count     <= '0;
        end else begin
            state          <= state_nxt;
            method_r       <= method_nxt;
            remain_r       <= remain_nxt;
            first_r        <= first_nxt;
            err_bad_method <= bad;
            msg_count      <= msg_count + 32'(inc_msg);
            drop_count     <= (inc_drop && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
        end
    end

    xsim_msg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (push),
        .push_data (push_entry),
        .pop       (out_valid && out_ready),
        .head      (head),
        .full      (full),
        .empty     (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_data   = head.data;
    assign out_method = head.method;
    assign out_first  = head.first;
    assign out_last   = head.last;
    assign out_empty  = head.empty;

endmodule
